// File: rtl/arith_issue_queue.sv
// Arithmetic reservation station: holds dispatched uops until both operands are
// captured (at dispatch or from the CDB), then issues the lowest ready entry per cycle.
module arith_issue_queue #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned ROB_SIZE      = 256,
  parameter int unsigned PHYS_REG_SIZE = 256,
  parameter int unsigned UOP_SIZE      = 16,
  parameter int unsigned RS_SIZE       = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             disp_valid,
  output logic                             disp_ready,
  input  logic [$clog2(UOP_SIZE)-1:0]      disp_uop,
  input  logic [$clog2(ROB_SIZE)-1:0]      disp_rob_entry,
  input  logic [$clog2(PHYS_REG_SIZE)-1:0] disp_dest_reg,
  input  logic [XLEN-1:0]                  disp_pc,
  input  logic [$clog2(PHYS_REG_SIZE)-1:0] disp_src1_tag,
  input  logic [$clog2(PHYS_REG_SIZE)-1:0] disp_src2_tag,
  input  logic                             disp_src1_rdy,
  input  logic                             disp_src2_rdy,
  input  logic [XLEN-1:0]                  disp_src1_val,
  input  logic [XLEN-1:0]                  disp_src2_val,
  input  logic                             cdb_valid,
  input  logic [$clog2(PHYS_REG_SIZE)-1:0] cdb_tag,
  input  logic [XLEN-1:0]                  cdb_value,
  output logic                             valid_out,
  output logic [$clog2(UOP_SIZE)-1:0]      uop,
  output logic [$clog2(ROB_SIZE)-1:0]      rob_entry,
  output logic [$clog2(PHYS_REG_SIZE)-1:0] dest_reg,
  output logic [XLEN-1:0]                  rs1,
  output logic [XLEN-1:0]                  rs2,
  output logic [XLEN-1:0]                  pc,
  output logic [$clog2(RS_SIZE):0]         occupancy
);

  localparam int unsigned UOP_W = $clog2(UOP_SIZE);
  localparam int unsigned ROB_W = $clog2(ROB_SIZE);
  localparam int unsigned REG_W = $clog2(PHYS_REG_SIZE);
  localparam int unsigned IDX_W = $clog2(RS_SIZE);
  localparam int unsigned OCC_W = IDX_W + 1;

  typedef struct packed {
    logic [UOP_W-1:0] uop;
    logic [ROB_W-1:0] rob;
    logic [REG_W-1:0] dest;
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] s1_tag;
    logic             s1_rdy;
    logic [XLEN-1:0]  s1_val;
    logic [REG_W-1:0] s2_tag;
    logic             s2_rdy;
    logic [XLEN-1:0]  s2_val;
  } entry_t;

  typedef struct packed {
    logic [UOP_W-1:0] uop;
    logic [ROB_W-1:0] rob;
    logic [REG_W-1:0] dest;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [XLEN-1:0]  pc;
  } issue_t;

  logic [RS_SIZE-1:0] valid_q, valid_d;
  entry_t             ent_q [RS_SIZE];
  entry_t             ent_d [RS_SIZE];
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               rdy_q, rdy_d;
  logic               out_vld_q, out_vld_d;
  issue_t             pkt_q, pkt_d;

  logic               sel_hit, free_hit, accept;
  logic [IDX_W-1:0]   sel_idx, free_idx;
  logic               byp1, byp2;
  entry_t             new_ent;

  assign accept = disp_valid && rdy_q;

  // Lowest-index ready entry and lowest-index free slot, from cycle-start state
  always_comb begin
    sel_hit  = 1'b0;
    sel_idx  = '0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      if (!sel_hit && valid_q[i] && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
        sel_hit = 1'b1;
        sel_idx = IDX_W'(i);
      end
      if (!free_hit && !valid_q[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Incoming entry, with operands captured from a same-cycle CDB broadcast
  always_comb begin
    byp1           = !disp_src1_rdy && cdb_valid && (disp_src1_tag == cdb_tag);
    byp2           = !disp_src2_rdy && cdb_valid && (disp_src2_tag == cdb_tag);
    new_ent        = '0;
    new_ent.uop    = disp_uop;
    new_ent.rob    = disp_rob_entry;
    new_ent.dest   = disp_dest_reg;
    new_ent.pc     = disp_pc;
    new_ent.s1_tag = disp_src1_tag;
    new_ent.s1_rdy = disp_src1_rdy || byp1;
    new_ent.s1_val = byp1 ? cdb_value : disp_src1_val;
    new_ent.s2_tag = disp_src2_tag;
    new_ent.s2_rdy = disp_src2_rdy || byp2;
    new_ent.s2_val = byp2 ? cdb_value : disp_src2_val;
  end

  always_comb begin
    valid_d   = valid_q;
    occ_d     = occ_q;
    out_vld_d = 1'b0;
    pkt_d     = pkt_q;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      ent_d[i] = ent_q[i];
      if (valid_q[i] && cdb_valid) begin
        if (!ent_q[i].s1_rdy && ent_q[i].s1_tag == cdb_tag) begin
          ent_d[i].s1_rdy = 1'b1;
          ent_d[i].s1_val = cdb_value;
        end
        if (!ent_q[i].s2_rdy && ent_q[i].s2_tag == cdb_tag) begin
          ent_d[i].s2_rdy = 1'b1;
          ent_d[i].s2_val = cdb_value;
        end
      end
    end
    if (sel_hit) begin
      valid_d[sel_idx] = 1'b0;
      out_vld_d        = 1'b1;
      pkt_d.uop        = ent_q[sel_idx].uop;
      pkt_d.rob        = ent_q[sel_idx].rob;
      pkt_d.dest       = ent_q[sel_idx].dest;
      pkt_d.rs1        = ent_q[sel_idx].s1_val;
      pkt_d.rs2        = ent_q[sel_idx].s2_val;
      pkt_d.pc         = ent_q[sel_idx].pc;
    end
    if (accept) begin
      valid_d[free_idx] = 1'b1;
      ent_d[free_idx]   = new_ent;
    end
    occ_d = occ_q + OCC_W'(accept) - OCC_W'(sel_hit);
    // Flush drops everything, including a same-cycle dispatch and issue
    if (flush) begin
      valid_d   = '0;
      occ_d     = '0;
      out_vld_d = 1'b0;
      pkt_d     = pkt_q;
    end
    rdy_d = (occ_d != OCC_W'(RS_SIZE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      occ_q     <= '0;
      rdy_q     <= 1'b1;
      out_vld_q <= 1'b0;
      pkt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      occ_q     <= occ_d;
      rdy_q     <= rdy_d;
      out_vld_q <= out_vld_d;
      pkt_q     <= pkt_d;
    end
  end

  // Entry payload is qualified by valid_q, so it needs no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      ent_q[i] <= ent_d[i];
    end
  end

  assign disp_ready = rdy_q;
  assign occupancy  = occ_q;
  assign valid_out  = out_vld_q;
  assign uop        = pkt_q.uop;
  assign rob_entry  = pkt_q.rob;
  assign dest_reg   = pkt_q.dest;
  assign rs1        = pkt_q.rs1;
  assign rs2        = pkt_q.rs2;
  assign pc         = pkt_q.pc;

endmodule

// File: doc/arith_issue_queue.md
Name: arith_issue_queue

Overview:
- Reservation station directly upstream of the arithmetic functional unit.
- Holds dispatched arithmetic uops until both source operands are available, capturing operand values from the common data bus (CDB) as they arrive.
- Issues at most one ready uop per cycle as a registered packet: uop, rob entry, dest reg, rs1, rs2, pc.
- Supports a full flush on branch mispredict.

Parameters:
- XLEN, 32, datapath / operand width
- ROB_SIZE, 256, ROB depth; rob tag width = $clog2(ROB_SIZE)
- PHYS_REG_SIZE, 256, physical regfile size; reg tag width = $clog2(PHYS_REG_SIZE)
- UOP_SIZE, 16, uop encoding space; uop width = $clog2(UOP_SIZE)
- RS_SIZE, 8, number of queue entries (power of two, >=2)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  drop all entries and any pending issue
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept a dispatch this cycle
- disp_uop  in  $clog2(UOP_SIZE)  uop code
- disp_rob_entry  in  $clog2(ROB_SIZE)  ROB tag
- disp_dest_reg  in  $clog2(PHYS_REG_SIZE)  destination physical reg
- disp_pc  in  XLEN  instruction pc
- disp_src1_tag, disp_src2_tag  in  $clog2(PHYS_REG_SIZE)  source physical regs
- disp_src1_rdy, disp_src2_rdy  in  1  operand value already valid
- disp_src1_val, disp_src2_val  in  XLEN  operand value (meaningful only when rdy=1)
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  $clog2(PHYS_REG_SIZE)  broadcast physical reg
- cdb_value  in  XLEN  broadcast result
- valid_out  out  1  issue packet valid (registered)
- uop  out  $clog2(UOP_SIZE)  issued uop
- rob_entry  out  $clog2(ROB_SIZE)  issued ROB tag
- dest_reg  out  $clog2(PHYS_REG_SIZE)  issued dest reg
- rs1, rs2  out  XLEN  operand values
- pc  out  XLEN  issued pc
- occupancy  out  $clog2(RS_SIZE)+1  number of valid entries

Behaviour:
- Reset (rst=1 at posedge):
  - All entry valid bits cleared; occupancy=0.
  - valid_out=0; uop, rob_entry, dest_reg, rs1, rs2, pc all =0.
  - disp_ready=1 from the first cycle after reset.
  - rst overrides flush, dispatch and CDB.
- Dispatch:
  - Accepted when disp_valid && disp_ready.
  - disp_ready = (occupancy != RS_SIZE). An entry freed by issue in the same cycle does not raise disp_ready that cycle.
  - Written into the lowest-index free entry at posedge.
  - A new entry is never selected for issue in the cycle it is dispatched; earliest issue is the next cycle, packet visible the cycle after.
- Wakeup:
  - Every cycle, each valid entry with srcN_rdy=0 and srcN_tag==cdb_tag while cdb_valid=1 sets srcN_rdy=1 and srcN_val=cdb_value at posedge.
  - Applies to both sources independently, including src1_tag==src2_tag.
  - Dispatch bypass: if a dispatching operand has rdy=0 and its tag matches a same-cycle CDB broadcast, the entry is written with rdy=1 and val=cdb_value.
  - Operands already ready ignore the CDB.
- Select/issue:
  - Each cycle, combinationally pick the lowest-index entry with valid && src1_rdy && src2_rdy, using state at cycle start; same-cycle wakeups are not visible.
  - At posedge: the packet is registered onto the outputs with valid_out=1 and the entry is freed.
  - If no entry is ready: valid_out=0 and the payload outputs hold their previous values.
  - Issue latency: ready-at-cycle-start t -> valid_out high in cycle t+1.
  - The FU provides no backpressure; valid_out is a one-cycle pulse per issued uop.
- Occupancy: next = occupancy + accepted_dispatch - issued. Simultaneous dispatch and issue leave it unchanged.
- Flush (flush=1 at posedge, rst=0):
  - All entries invalidated; occupancy=0; valid_out=0 next cycle.
  - A same-cycle dispatch is discarded, and so is a same-cycle issue.
- Uop values are opaque to the queue; no decoding is done.

Test Plan:
- Reset then dispatch uop=0, rob=5, dest=9, src1 rdy val=7, src2 rdy val=3 at cycle 0 -> valid_out=1 in cycle 2 with rs1=7, rs2=3, rob_entry=5, dest_reg=9; occupancy returns to 0.
- Dispatch with src2_tag=20 not ready; CDB tag=20 value=0xDEAD two cycles later -> issue packet one cycle after the broadcast edge has rs2=0xDEAD; no issue before the broadcast.
- Same-cycle bypass: dispatch src1_tag=4 rdy=0 while cdb_tag=4 value=11 -> entry ready immediately; rs1=11 appears at the standard 2-cycle latency.
- Fill 8 entries, all waiting on tag 30 -> disp_ready=0, occupancy=8, a 9th disp_valid is ignored. Then CDB tag=30 -> entries issue one per cycle in index order 0..7.
- Full queue, one entry issues while disp_valid=1 -> no dispatch that cycle; dispatch accepted the next cycle; occupancy correct throughout.
- Flush with 5 entries and a ready entry pending -> next cycle valid_out=0, occupancy=0, disp_ready=1. Assert rst mid-stream -> all outputs 0.
